// File: rtl/pool_bank_buffer_pkg.sv
// Shared types and default sizes for the pooled-frame bank buffer.
// State encoding is fixed because downstream debug taps decode it directly.
package pool_bank_buffer_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        READY = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam int BD_DEF = 18;
    localparam int AW_DEF = 11;
    localparam int W_DEF  = 3 * BD_DEF;

endpackage

// File: rtl/pool_bank_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
// Contents are not reset; only the read register is.
module pool_bank_ram #(
    parameter int W     = 54,
    parameter int IW    = 11,
    parameter int DEPTH = 2048
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [IW-1:0] raddr,
    output logic [W-1:0]  q
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (re) begin
            q <= mem[raddr];
        end
    end

endmodule

// File: rtl/pool_bank_buffer.sv
// Four-bank frame buffer between maxPool and the next conv layer.
// Fills while in FILL, locks on next_st, serves reads to the consumer in READ.
//
//   state | meaning
//   FILL  | accepting maxPool writes, reads ignored
//   READY | frame locked, waiting for consumer start_rd
//   READ  | consumer reading banks, waiting for fin_rd
module pool_bank_buffer
    import pool_bank_buffer_pkg::*;
#(
    parameter int BD    = BD_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = 2048
) (
    input  logic            clk,
    input  logic            RESET,
    input  logic            wren,
    input  logic [AW-1:0]   wraddr,
    input  logic [1:0]      bram_num,
    input  logic [BD-1:0]   d_c0,
    input  logic [BD-1:0]   d_c1,
    input  logic [BD-1:0]   d_c2,
    input  logic            next_st,
    input  logic            start_rd,
    input  logic            fin_rd,
    input  logic [3:0]      rden,
    input  logic [AW-1:0]   rd_addr,
    output logic            ready,
    output logic            busy,
    output logic            de_out,
    output logic [3*BD-1:0] q0,
    output logic [3*BD-1:0] q1,
    output logic [3*BD-1:0] q2,
    output logic [3*BD-1:0] q3,
    output logic            wr_drop
);

    localparam int W  = 3 * BD;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t state_q, state_d;

    logic         wr_in_range, rd_in_range, wr_ok;
    logic [3:0]   rd_fire;
    logic [3:0]   oor_q;
    logic [W-1:0] wdata;
    logic [W-1:0] ram_q  [4];
    logic [W-1:0] q_bank [4];

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (next_st)  state_d = READY;
            READY:   if (start_rd) state_d = READ;
            READ:    if (fin_rd)   state_d = FILL;
            default:               state_d = FILL;
        endcase
    end

    assign ready = (state_q == READY);
    assign busy  = (state_q == READ);

    assign wr_in_range = ({1'b0, wraddr} < DEPTH_L);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
    assign wr_ok       = wren && (state_q == FILL) && wr_in_range;
    assign rd_fire     = rden & {4{state_q == READ}};
    assign wdata       = {d_c2, d_c1, d_c0};

    // oor_q remembers that a bank's last honoured read was out of range, so the
    // zeroed output holds just like a normal read result would.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            de_out  <= 1'b0;
            wr_drop <= 1'b0;
            oor_q   <= '0;
        end else begin
            de_out <= |rd_fire;
            if (wren && !wr_ok) begin
                wr_drop <= 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (rd_fire[i]) begin
                    oor_q[i] <= !rd_in_range;
                end
            end
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_bank
        pool_bank_ram #(
            .W     (W),
            .IW    (IW),
            .DEPTH (DEPTH)
        ) u_ram (
            .clk   (clk),
            .rst_n (RESET),
            .we    (wr_ok && (bram_num == 2'(i))),
            .waddr (wraddr[IW-1:0]),
            .wdata (wdata),
            .re    (rd_fire[i] && rd_in_range),
            .raddr (rd_addr[IW-1:0]),
            .q     (ram_q[i])
        );

        assign q_bank[i] = oor_q[i] ? '0 : ram_q[i];
    end

    assign q0 = q_bank[0];
    assign q1 = q_bank[1];
    assign q2 = q_bank[2];
    assign q3 = q_bank[3];

endmodule

// File: tb/tb_pool_bank_buffer.sv
// Directed bench for pool_bank_buffer; a second instance with DEPTH=1024
// shares all inputs and is used for the out-of-range cases.
module tb_pool_bank_buffer;

    localparam int BD = 18;
    localparam int AW = 11;
    localparam int W  = 3 * BD;

    logic          clk = 1'b0;
    logic          RESET = 1'b0;
    logic          wren = 1'b0;
    logic [AW-1:0] wraddr = '0;
    logic [1:0]    bram_num = '0;
    logic [BD-1:0] d_c0 = '0, d_c1 = '0, d_c2 = '0;
    logic          next_st = 1'b0, start_rd = 1'b0, fin_rd = 1'b0;
    logic [3:0]    rden = '0;
    logic [AW-1:0] rd_addr = '0;

    logic          ready, busy, de_out, wr_drop;
    logic [W-1:0]  q0, q1, q2, q3;
    logic          s_ready, s_busy, s_de_out, s_wr_drop;
    logic [W-1:0]  s_q0, s_q1, s_q2, s_q3;

    int checks   = 0;
    int failures = 0;

    pool_bank_buffer #(.BD(BD), .AW(AW), .DEPTH(2048)) dut (
        .clk(clk), .RESET(RESET), .wren(wren), .wraddr(wraddr), .bram_num(bram_num),
        .d_c0(d_c0), .d_c1(d_c1), .d_c2(d_c2), .next_st(next_st), .start_rd(start_rd),
        .fin_rd(fin_rd), .rden(rden), .rd_addr(rd_addr), .ready(ready), .busy(busy),
        .de_out(de_out), .q0(q0), .q1(q1), .q2(q2), .q3(q3), .wr_drop(wr_drop)
    );

    pool_bank_buffer #(.BD(BD), .AW(AW), .DEPTH(1024)) dut_s (
        .clk(clk), .RESET(RESET), .wren(wren), .wraddr(wraddr), .bram_num(bram_num),
        .d_c0(d_c0), .d_c1(d_c1), .d_c2(d_c2), .next_st(next_st), .start_rd(start_rd),
        .fin_rd(fin_rd), .rden(rden), .rd_addr(rd_addr), .ready(s_ready), .busy(s_busy),
        .de_out(s_de_out), .q0(s_q0), .q1(s_q1), .q2(s_q2), .q3(s_q3), .wr_drop(s_wr_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] wd(input int c0, input int c1, input int c2);
        return {BD'(c2), BD'(c1), BD'(c0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int bank, input int addr, input int c0, input int c1, input int c2);
        wren = 1'b1; bram_num = 2'(bank); wraddr = AW'(addr);
        d_c0 = BD'(c0); d_c1 = BD'(c1); d_c2 = BD'(c2);
        tick();
        wren = 1'b0;
    endtask

    task automatic rd(input logic [3:0] mask, input int addr);
        rden = mask; rd_addr = AW'(addr);
        tick();
        rden = '0;
    endtask

    task automatic pulse_next();
        next_st = 1'b1; tick(); next_st = 1'b0;
    endtask

    task automatic pulse_start();
        start_rd = 1'b1; tick(); start_rd = 1'b0;
    endtask

    task automatic pulse_fin();
        fin_rd = 1'b1; tick(); fin_rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        RESET = 1'b0;
        tick(); tick();
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_de_out", 64'(de_out), 64'd0);
        check("rst_wr_drop", 64'(wr_drop), 64'd0);
        check("rst_q0", 64'(q0), 64'd0);
        RESET = 1'b1;
        tick();

        // basic fill and read
        for (int i = 0; i < 4; i++) wr(0, i, i + 1, i + 17, i + 33);
        pulse_start();
        check("start_in_fill_ignored", 64'(busy), 64'd0);
        pulse_next();
        check("lock_ready", 64'(ready), 64'd1);
        pulse_start();
        check("read_busy", 64'(busy), 64'd1);
        check("read_ready", 64'(ready), 64'd0);
        rd(4'b0001, 2);
        check("basic_q0", 64'(q0), 64'(wd(3, 19, 35)));
        check("basic_de_out", 64'(de_out), 64'd1);
        tick();
        check("de_out_idle", 64'(de_out), 64'd0);
        check("q0_holds", 64'(q0), 64'(wd(3, 19, 35)));
        pulse_fin();
        check("fin_to_fill", 64'(busy), 64'd0);

        // bank interleave
        for (int b = 0; b < 4; b++) wr(b, 5, 16 * (b + 1), 0, 0);
        pulse_next();
        pulse_start();
        rd(4'b1111, 5);
        check("ilv_q0", 64'(q0), 64'(wd(16'h10, 0, 0)));
        check("ilv_q1", 64'(q1), 64'(wd(16'h20, 0, 0)));
        check("ilv_q2", 64'(q2), 64'(wd(16'h30, 0, 0)));
        check("ilv_q3", 64'(q3), 64'(wd(16'h40, 0, 0)));
        check("ilv_de_out", 64'(de_out), 64'd1);
        pulse_fin();

        // write drop outside FILL
        wr(1, 0, 7, 0, 0);
        pulse_next();
        check("drop_pre", 64'(wr_drop), 64'd0);
        wr(1, 0, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF);
        check("drop_set", 64'(wr_drop), 64'd1);
        pulse_next();
        check("next_in_ready_ignored", 64'(ready), 64'd1);
        pulse_fin();
        check("fin_in_ready_ignored", 64'(ready), 64'd1);
        pulse_start();
        rd(4'b0010, 0);
        check("drop_kept_old", 64'(q1), 64'(wd(7, 0, 0)));
        pulse_fin();
        check("drop_sticky", 64'(wr_drop), 64'd1);
        rd(4'b1111, 1);
        check("rd_in_fill_de", 64'(de_out), 64'd0);
        check("rd_in_fill_hold", 64'(q1), 64'(wd(7, 0, 0)));

        // simultaneous events
        wren = 1'b1; bram_num = 2'd2; wraddr = AW'(7);
        d_c0 = BD'(8'h55); d_c1 = '0; d_c2 = '0; next_st = 1'b1;
        tick();
        wren = 1'b0; next_st = 1'b0;
        check("wr_next_ready", 64'(ready), 64'd1);
        start_rd = 1'b1; fin_rd = 1'b1;
        tick();
        start_rd = 1'b0; fin_rd = 1'b0;
        check("start_fin_busy", 64'(busy), 64'd1);
        rd(4'b0100, 7);
        check("wr_next_stored", 64'(q2), 64'(wd(8'h55, 0, 0)));

        // reset mid-READ
        check("pre_rst_busy", 64'(busy), 64'd1);
        rden = 4'b1111;
        #2;
        RESET = 1'b0;
        #1;
        check("arst_ready", 64'(ready), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_de_out", 64'(de_out), 64'd0);
        check("arst_q", 64'(|{q0, q1, q2, q3}), 64'd0);
        check("arst_wr_drop", 64'(wr_drop), 64'd0);
        tick();
        RESET = 1'b1;
        tick();
        rden = '0;
        check("rel_read_ignored", 64'(de_out), 64'd0);
        wr(3, 9, 8'h99, 0, 0);
        pulse_next();
        pulse_start();
        rd(4'b1000, 9);
        check("post_rst_write", 64'(q3), 64'(wd(8'h99, 0, 0)));
        check("post_rst_q0", 64'(q0), 64'd0);
        check("post_rst_nodrop", 64'(wr_drop), 64'd0);
        pulse_fin();

        // out of range on the DEPTH=1024 instance
        wr(0, 1024, 12'h123, 0, 0);
        check("oor_wr_drop", 64'(s_wr_drop), 64'd1);
        check("inrange_no_drop", 64'(wr_drop), 64'd0);
        pulse_next();
        pulse_start();
        rd(4'b0001, 5);
        check("s_q0_addr5", 64'(s_q0), 64'(wd(16'h10, 0, 0)));
        rd(4'b0001, 1024);
        check("oor_q0_zero", 64'(s_q0), 64'd0);
        check("oor_de_out", 64'(s_de_out), 64'd1);
        check("big_q0_1024", 64'(q0), 64'(wd(12'h123, 0, 0)));
        tick();
        check("oor_q0_holds", 64'(s_q0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
